// File: rtl/commit_trace_checker_pkg.sv
// Shared definitions for the commit trace checker.
// Record layout (83 bits, the same for commit and expected records):
//   [82:71] reserved, not compared
//   [70] halt  [69] regwrite  [68] memread  [67] memwrite  [66:64] wreg
//   [63:48] pc  [47:32] wdata  [31:16] addr  [15:0] mdata
// Also holds the err_field codes, the FSM state encoding and the field compare.
package commit_trace_checker_pkg;

  localparam int unsigned RecW        = 83;
  localparam int unsigned UsedW       = 71;
  localparam int unsigned MdataLsb    = 0;
  localparam int unsigned AddrLsb     = 16;
  localparam int unsigned WdataLsb    = 32;
  localparam int unsigned PcLsb       = 48;
  localparam int unsigned WregLsb     = 64;
  localparam int unsigned MemwriteBit = 67;
  localparam int unsigned MemreadBit  = 68;
  localparam int unsigned RegwriteBit = 69;
  localparam int unsigned HaltBit     = 70;

  localparam logic [3:0] ErrPcFlags  = 4'b0001;
  localparam logic [3:0] ErrWdata    = 4'b0010;
  localparam logic [3:0] ErrAddr     = 4'b0100;
  localparam logic [3:0] ErrMdata    = 4'b1000;
  localparam logic [3:0] ErrOverflow = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } state_e;

  // Returns one bit per mismatching field group. Which groups are checked is
  // decided by the flags of the expected record only.
  function automatic logic [3:0] cmp_fields(input logic [RecW-1:0] act_rec,
                                            input logic [RecW-1:0] exp_rec);
    logic [3:0] f;
    f = '0;
    if ((act_rec[PcLsb +: 16] != exp_rec[PcLsb +: 16]) ||
        (act_rec[HaltBit:MemwriteBit] != exp_rec[HaltBit:MemwriteBit])) begin
      f = f | ErrPcFlags;
    end
    if (exp_rec[RegwriteBit] &&
        ((act_rec[WregLsb +: 3] != exp_rec[WregLsb +: 3]) ||
         (act_rec[WdataLsb +: 16] != exp_rec[WdataLsb +: 16]))) begin
      f = f | ErrWdata;
    end
    if ((exp_rec[MemreadBit] || exp_rec[MemwriteBit]) &&
        (act_rec[AddrLsb +: 16] != exp_rec[AddrLsb +: 16])) begin
      f = f | ErrAddr;
    end
    if (exp_rec[MemwriteBit] && (act_rec[MdataLsb +: 16] != exp_rec[MdataLsb +: 16])) begin
      f = f | ErrMdata;
    end
    return f;
  endfunction

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// Synchronous FIFO used as the commit record buffer.
// Ports: clk/rst (sync, active high), push_i/wdata_i write side, pop_i read side,
// rdata_o is the current head (valid while !empty_o), full_o/empty_o status.
// A push while full is ignored unless a pop happens in the same cycle.
module commit_trace_checker_fifo #(
  parameter int unsigned Width = 83,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]      wptr_q, wptr_d;
  logic [PtrW:0]      rptr_q, rptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push;
  logic               do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      wptr_d = wptr_q + (PtrW + 1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (PtrW + 1)'(1);
    end
  end

  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Commit trace checker: buffers retired-instruction records, fetches the
// expected record for each one and compares the fields the expected record
// enables. Reports pass, fail or buffer overflow with the failing inum.
// Ports: clk/rst (sync, active high); cmt_* commit record in; exp_rd_en /
// exp_rd_addr read request out, exp_rd_valid / exp_rd_data response in;
// inst_count, done, pass, err, err_inum, err_field status out.
module commit_trace_checker
  import commit_trace_checker_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EXP_AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmt_valid,
  input  logic [15:0]       cmt_pc,
  input  logic              cmt_regwrite,
  input  logic [2:0]        cmt_wreg,
  input  logic [15:0]       cmt_wdata,
  input  logic              cmt_memread,
  input  logic              cmt_memwrite,
  input  logic [15:0]       cmt_addr,
  input  logic [15:0]       cmt_mdata,
  input  logic              cmt_halt,
  output logic              exp_rd_en,
  output logic [EXP_AW-1:0] exp_rd_addr,
  input  logic              exp_rd_valid,
  input  logic [RecW-1:0]   exp_rd_data,
  output logic [15:0]       inst_count,
  output logic              done,
  output logic              pass,
  output logic              err,
  output logic [15:0]       err_inum,
  output logic [3:0]        err_field
);

  state_e          state_q, state_d;
  logic [15:0]     inum_q, inum_d;
  logic [15:0]     inst_count_q, inst_count_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            err_q, err_d;
  logic [15:0]     err_inum_q, err_inum_d;
  logic [3:0]      err_field_q, err_field_d;

  logic [RecW-1:0] cmt_rec;
  logic [RecW-1:0] head_rec;
  logic            fifo_full;
  logic            fifo_empty;
  logic            active;
  logic            pop;
  logic            push;
  logic            overflow;
  logic [3:0]      mism;
  logic            unused_rsvd;

  assign cmt_rec = {{(RecW - UsedW){1'b0}}, cmt_halt, cmt_regwrite, cmt_memread, cmt_memwrite,
                    cmt_wreg, cmt_pc, cmt_wdata, cmt_addr, cmt_mdata};

  assign unused_rsvd = ^{exp_rd_data[RecW-1:UsedW], head_rec[RecW-1:UsedW]};

  always_comb begin
    active   = (state_q == StIdle) || (state_q == StWait);
    // The head is consumed in the cycle its expected record arrives.
    pop      = (state_q == StWait) && exp_rd_valid;
    overflow = active && cmt_valid && fifo_full && !pop;
    push     = active && cmt_valid && !overflow;
    mism     = cmp_fields(head_rec, exp_rd_data);
  end

  commit_trace_checker_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (cmt_rec),
    .pop_i   (pop),
    .rdata_o (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    inum_d       = inum_q;
    inst_count_d = inst_count_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    err_inum_d   = err_inum_q;
    err_field_d  = err_field_q;
    exp_rd_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !overflow) begin
          exp_rd_en = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (exp_rd_valid) begin
          inum_d = inum_q + 16'd1;
          if (inst_count_q != 16'hFFFF) begin
            inst_count_d = inst_count_q + 16'd1;
          end
          if (|mism) begin
            state_d     = StFail;
            done_d      = 1'b1;
            err_d       = 1'b1;
            err_inum_d  = inum_q;
            err_field_d = mism;
          end else if (head_rec[HaltBit]) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDone, StFail: begin
      end
    endcase

    // Overflow outranks any compare result in the same cycle.
    if (overflow) begin
      state_d     = StFail;
      done_d      = 1'b1;
      pass_d      = 1'b0;
      err_d       = 1'b1;
      err_inum_d  = inum_q;
      err_field_d = ErrOverflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      inum_q       <= '0;
      inst_count_q <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
      err_inum_q   <= '0;
      err_field_q  <= '0;
    end else begin
      state_q      <= state_d;
      inum_q       <= inum_d;
      inst_count_q <= inst_count_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      err_inum_q   <= err_inum_d;
      err_field_q  <= err_field_d;
    end
  end

  assign exp_rd_addr = inum_q[EXP_AW-1:0];
  assign inst_count  = inst_count_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err         = err_q;
  assign err_inum    = err_inum_q;
  assign err_field   = err_field_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Testbench for commit_trace_checker: expected-trace memory responder,
// sequence-level reference model feeding a scoreboard queue, and a monitor
// that checks every status change the DUT presents.
module tb_commit_trace_checker;

  localparam int unsigned ExpAw = 10;

  typedef struct packed {
    logic        halt;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [2:0]  wreg;
    logic [15:0] pc;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  typedef struct packed {
    logic [15:0] count;
    logic        done;
    logic        pass;
    logic        err;
    logic [15:0] inum;
    logic [3:0]  field;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic cmt_valid, cmt_regwrite, cmt_memread, cmt_memwrite, cmt_halt;
  logic [15:0] cmt_pc, cmt_wdata, cmt_addr, cmt_mdata;
  logic [2:0]  cmt_wreg;
  logic        exp_rd_en, exp_rd_valid;
  logic [ExpAw-1:0] exp_rd_addr;
  rec_t        exp_rd_rec;
  logic [15:0] inst_count, err_inum;
  logic        done, pass, err;
  logic [3:0]  err_field;

  always #5 clk = ~clk;

  commit_trace_checker #(
    .FIFO_DEPTH (4),
    .EXP_AW     (ExpAw)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmt_valid    (cmt_valid),
    .cmt_pc       (cmt_pc),
    .cmt_regwrite (cmt_regwrite),
    .cmt_wreg     (cmt_wreg),
    .cmt_wdata    (cmt_wdata),
    .cmt_memread  (cmt_memread),
    .cmt_memwrite (cmt_memwrite),
    .cmt_addr     (cmt_addr),
    .cmt_mdata    (cmt_mdata),
    .cmt_halt     (cmt_halt),
    .exp_rd_en    (exp_rd_en),
    .exp_rd_addr  (exp_rd_addr),
    .exp_rd_valid (exp_rd_valid),
    .exp_rd_data  ({12'h000, exp_rd_rec}),
    .inst_count   (inst_count),
    .done         (done),
    .pass         (pass),
    .err          (err),
    .err_inum     (err_inum),
    .err_field    (err_field)
  );

  rec_t exp_mem  [1024];
  rec_t exp_list [64];
  rec_t cmt_list [64];
  res_t sb_q [$];

  int checks = 0;
  int failures = 0;
  bit auto_resp = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  logic [ExpAw-1:0] last_req_addr = '0;
  int rd_after_done = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Compare rules as stated for the trace: which groups are checked depends on
  // the expected record's flags.
  function automatic logic [3:0] model_fields(input rec_t c, input rec_t e);
    logic [3:0] f;
    f = 4'b0000;
    f[0] = (c.pc != e.pc) ||
           ({c.halt, c.regwrite, c.memread, c.memwrite} !=
            {e.halt, e.regwrite, e.memread, e.memwrite});
    f[1] = e.regwrite && ((c.wreg != e.wreg) || (c.wdata != e.wdata));
    f[2] = (e.memread || e.memwrite) && (c.addr != e.addr);
    f[3] = e.memwrite && (c.mdata != e.mdata);
    return f;
  endfunction

  function automatic rec_t mk(input logic h, input logic rw, input logic mr, input logic mw,
                              input logic [2:0] wr, input logic [15:0] pc,
                              input logic [15:0] wd, input logic [15:0] ad,
                              input logic [15:0] md);
    rec_t r;
    r.halt = h; r.regwrite = rw; r.memread = mr; r.memwrite = mw; r.wreg = wr;
    r.pc = pc; r.wdata = wd; r.addr = ad; r.mdata = md;
    return r;
  endfunction

  // Walks the commit list in order and predicts every status change: one per
  // checked record, stopping at the first mismatch or matching HALT.
  task automatic model_push(input int n);
    res_t r;
    logic [3:0] f;
    for (int i = 0; i < n; i++) begin
      f = model_fields(cmt_list[i], exp_list[i]);
      r = '0;
      r.count = 16'(i + 1);
      if (f != 4'b0000) begin
        r.done = 1'b1; r.err = 1'b1; r.inum = 16'(i); r.field = f;
        sb_q.push_back(r);
        break;
      end
      if (exp_list[i].halt) begin
        r.done = 1'b1; r.pass = 1'b1;
        sb_q.push_back(r);
        break;
      end
      sb_q.push_back(r);
    end
  endtask

  task automatic commit(input rec_t r);
    cmt_pc = r.pc; cmt_regwrite = r.regwrite; cmt_wreg = r.wreg; cmt_wdata = r.wdata;
    cmt_memread = r.memread; cmt_memwrite = r.memwrite; cmt_addr = r.addr;
    cmt_mdata = r.mdata; cmt_halt = r.halt;
    cmt_valid = 1'b1;
    @(posedge clk); #1;
    cmt_valid = 1'b0;
  endtask

  task automatic do_reset();
    sb_q.delete();
    cmt_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic load_mem(input int n);
    for (int i = 0; i < n; i++) exp_mem[i] = exp_list[i];
  endtask

  // Keeps at most three records buffered so the FIFO never overflows.
  task automatic drive_paced(input int n, input int maxgap);
    int g;
    for (int j = 0; j < n; j++) begin
      g = 0;
      while (!done && (int'(inst_count) + 2 < j) && g < 300) begin
        @(posedge clk); #1; g++;
      end
      if (g >= 300) chk("pace_timeout", 64'(inst_count), 64'(j));
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
      commit(cmt_list[j]);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 400) begin @(posedge clk); #1; g++; end
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic run_list(input int n, input int maxgap);
    int base;
    base = rd_after_done;
    load_mem(n);
    model_push(n);
    drive_paced(n, maxgap);
    wait_drain();
    chk("final_done", 64'(done), 64'(1));
    chk("no_read_after_done", 64'(rd_after_done - base), 64'(0));
    do_reset();
  endtask

  function automatic rec_t inject(input rec_t c);
    int k;
    k = $urandom_range(15, 0);
    case ($urandom_range(5, 0))
      0: c.pc = c.pc ^ (16'd1 << k);
      1: case ($urandom_range(3, 0))
           0: c.halt = ~c.halt;
           1: c.regwrite = ~c.regwrite;
           2: c.memread = ~c.memread;
           default: c.memwrite = ~c.memwrite;
         endcase
      2: c.wreg = c.wreg ^ 3'(1 << (k % 3));
      3: c.wdata = c.wdata ^ (16'd1 << k);
      4: c.addr = c.addr ^ (16'd1 << k);
      default: c.mdata = c.mdata ^ (16'd1 << k);
    endcase
    return c;
  endfunction

  task automatic run_random(input int n, input int errpct);
    rec_t e, c;
    logic [15:0] pc0;
    pc0 = 16'($urandom_range(16'hFF00, 0));
    for (int i = 0; i < n; i++) begin
      e = rec_t'({$urandom, $urandom, $urandom});
      e.halt = 1'b0;
      {e.regwrite, e.memread, e.memwrite} = 3'b000;
      case ($urandom_range(3, 0))
        0: e.regwrite = 1'b1;
        1: begin e.regwrite = 1'b1; e.memread = 1'b1; end
        2: e.memwrite = 1'b1;
        default: ;
      endcase
      if (i == n - 1) begin
        {e.regwrite, e.memread, e.memwrite} = 3'b000;
        e.halt = 1'b1;
      end
      e.pc = pc0 + 16'(2 * i);
      c = e;
      if (!e.regwrite) begin c.wreg = 3'($urandom); c.wdata = 16'($urandom); end
      if (!(e.memread || e.memwrite)) c.addr = 16'($urandom);
      if (!e.memwrite) c.mdata = 16'($urandom);
      if ($urandom_range(99, 0) < errpct) c = inject(c);
      exp_list[i] = e;
      cmt_list[i] = c;
    end
    run_list(n, 2);
  endtask

  // Expected-trace memory: answers each request after lat_min..lat_max cycles.
  // It does not watch rst, so a reset mid-read yields a late response.
  initial begin
    exp_rd_valid = 1'b0;
    exp_rd_rec = '0;
    forever begin
      @(negedge clk);
      if (auto_resp && !rst && exp_rd_en) begin
        int lat;
        logic [ExpAw-1:0] a;
        a = exp_rd_addr;
        last_req_addr = a;
        lat = $urandom_range(lat_max, lat_min);
        @(posedge clk); #1;
        repeat (lat - 1) begin @(posedge clk); #1; end
        exp_rd_rec = exp_mem[a];
        exp_rd_valid = 1'b1;
        @(posedge clk); #1;
        exp_rd_valid = 1'b0;
        exp_rd_rec = rec_t'({$urandom, $urandom, $urandom});
      end
    end
  end

  // Monitor: any change of inst_count or a rising done is a DUT result.
  logic [15:0] mon_cnt = '0;
  logic        mon_done = 1'b0;
  logic        mon_valid = 1'b0;
  res_t        mon_act, mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done && exp_rd_en) rd_after_done++;
        if ((inst_count != mon_cnt) || (done && !mon_done)) begin
          mon_act.count = inst_count; mon_act.done = done; mon_act.pass = pass;
          mon_act.err = err; mon_act.inum = err_inum; mon_act.field = err_field;
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%h required=none", mon_act);
          end else begin
            mon_exp = sb_q.pop_front();
            chk("result", 64'(mon_act), 64'(mon_exp));
          end
          if (inst_count != mon_cnt) chk("result_latency", 64'(mon_valid), 64'(1));
        end
      end
      mon_cnt = inst_count;
      mon_done = done;
      mon_valid = exp_rd_valid;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmt_valid = 1'b0; cmt_pc = '0; cmt_regwrite = 1'b0; cmt_wreg = '0; cmt_wdata = '0;
    cmt_memread = 1'b0; cmt_memwrite = 1'b0; cmt_addr = '0; cmt_mdata = '0; cmt_halt = 1'b0;
    do_reset();
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_inst_count", 64'(inst_count), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_inum", 64'(err_inum), 64'(0));
    chk("rst_err_field", 64'(err_field), 64'(0));
    chk("rst_rd_en", 64'(exp_rd_en), 64'(0));

    auto_resp = 1'b1;
    lat_min = 1; lat_max = 1;

    // Three ALU commits then HALT at 0x0006, all matching.
    exp_list[0] = mk(0, 1, 0, 0, 3'd1, 16'h0000, 16'h0011, 16'hAAAA, 16'hBBBB);
    exp_list[1] = mk(0, 1, 0, 0, 3'd2, 16'h0002, 16'h1235, 16'hAAAA, 16'hBBBB);
    exp_list[2] = mk(0, 1, 0, 0, 3'd3, 16'h0004, 16'h0033, 16'hAAAA, 16'hBBBB);
    exp_list[3] = mk(1, 0, 0, 0, 3'd0, 16'h0006, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) cmt_list[i] = exp_list[i];
    run_list(4, 0);

    // Same trace, commit 1 carries wdata 0x1234.
    cmt_list[1].wdata = 16'h1234;
    run_list(4, 0);

    // Branch with garbage don't-care fields, then a store with bad mdata.
    exp_list[0] = mk(0, 0, 0, 0, 3'd0, 16'h0010, 16'h1111, 16'h2222, 16'h3333);
    exp_list[1] = mk(0, 0, 0, 1, 3'd0, 16'h0012, 16'h0000, 16'h0040, 16'h55AA);
    exp_list[2] = mk(1, 0, 0, 0, 3'd0, 16'h0014, 16'h0000, 16'h0000, 16'h0000);
    cmt_list[0] = mk(0, 0, 0, 0, 3'd5, 16'h0010, 16'hDEAD, 16'hBEEF, 16'h7777);
    cmt_list[1] = mk(0, 0, 0, 1, 3'd0, 16'h0012, 16'h0000, 16'h0040, 16'h55AB);
    cmt_list[2] = exp_list[2];
    run_list(3, 0);

    // Five back-to-back commits, the fifth coinciding with a pop: legal.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 5; i++) begin
      exp_list[i] = mk(i == 4, i != 4, 0, 0, 3'(i), 16'(16'h0100 + 2 * i), 16'(i * 7),
                       16'h0, 16'h0);
      cmt_list[i] = exp_list[i];
    end
    load_mem(5);
    model_push(5);
    for (int i = 0; i < 5; i++) commit(cmt_list[i]);
    wait_drain();
    chk("full_pop_pass", 64'(pass), 64'(1));
    do_reset();

    // Five back-to-back commits with no response: overflow on the fifth.
    auto_resp = 1'b0;
    mon_exp = '0;
    mon_exp.done = 1'b1; mon_exp.err = 1'b1; mon_exp.field = 4'hF;
    sb_q.push_back(mon_exp);
    for (int i = 0; i < 5; i++) commit(cmt_list[i]);
    wait_drain();
    chk("overflow_no_pass", 64'(pass), 64'(0));
    do_reset();

    // Reset with a read outstanding at index 2, then a late response.
    auto_resp = 1'b1;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      exp_list[i] = mk(0, 1, 0, 0, 3'(i + 1), 16'(16'h0200 + 2 * i), 16'(16'h0F00 + i),
                       16'h0, 16'h0);
      cmt_list[i] = exp_list[i];
    end
    cmt_list[2].wdata = 16'hFFFF;
    load_mem(3);
    model_push(2);
    drive_paced(2, 0);
    wait_drain();
    lat_min = 8; lat_max = 8;
    commit(cmt_list[2]);
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    repeat (14) begin @(posedge clk); #1; end
    chk("stale_req_addr", 64'(last_req_addr), 64'(2));
    chk("stale_inst_count", 64'(inst_count), 64'(0));
    chk("stale_err", 64'(err), 64'(0));
    chk("stale_done", 64'(done), 64'(0));
    lat_min = 1; lat_max = 1;
    exp_list[0] = mk(1, 0, 0, 0, 3'd0, 16'h0300, 16'h0, 16'h0, 16'h0);
    cmt_list[0] = exp_list[0];
    load_mem(1);
    model_push(1);
    drive_paced(1, 0);
    wait_drain();
    chk("restart_addr", 64'(last_req_addr), 64'(0));
    chk("restart_pass", 64'(pass), 64'(1));
    do_reset();

    // Randomized traces with random latency, gaps and injected faults.
    lat_min = 1; lat_max = 3;
    for (int r = 0; r < 30; r++) begin
      run_random($urandom_range(16, 2), 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
